cache_line_mover: RTL

//   Line transfer engine between the 4-way cache and main memory. Serialises a 512-bit

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_line_mover_if.sv | 36 +++
 rtl/cache_line_mover_beat_timer.sv | 27 ++
 rtl/cache_line_mover.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: geometry and state encoding shared by the cache line mover.
// Line/beat sizes, offset position and a beat-select helper.
package cache_pkg;
  localparam int LINE_W     = 512;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int IDX_W      = 4;
  localparam int OFFSET_LSB = 6;
  localparam int TAG_W      = 32 - OFFSET_LSB;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    DONE
  } state_t;

  function automatic logic [BEAT_W-1:0] line_word(
    input logic [LINE_W-1:0] l,
    input logic [IDX_W-1:0]  i
  );
    return l[{i, 5'b0} +: BEAT_W];
  endfunction
endpackage

// File: rtl/cache_line_mover_if.sv
// cache_line_mover_if: cache-side requests and memory beat bus.
// master = the line mover, slave = cache controller plus memory.
interface cache_line_mover_if;
  import cache_pkg::*;

  logic              fill_req;
  logic [31:0]       fill_addr;
  logic              wb_req;
  logic [31:0]       wb_addr;
  logic [LINE_W-1:0] wb_line;
  logic [LINE_W-1:0] fill_line;
  logic              fill_done;
  logic              wb_done;
  logic              busy;
  logic              mem_err;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    input  fill_req, fill_addr, wb_req, wb_addr, wb_line,
    input  mem_rdata, mem_ack,
    output fill_line, fill_done, wb_done, busy, mem_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output fill_req, fill_addr, wb_req, wb_addr, wb_line,
    output mem_rdata, mem_ack,
    input  fill_line, fill_done, wb_done, busy, mem_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_line_mover_beat_timer.sv
// beat_timer: counts cycles a memory beat waits for its ack.
// expired_o flags the last allowed waiting cycle.
module beat_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [CNT_W-1:0] cnt_q;

  // Restart on every new beat, count while the beat is unacked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/cache_line_mover.sv
// cache_line_mover: 512-bit line writeback/fill over a 32-bit beat bus.
// Optional CRITICAL_WORD_FIRST_EN starts fills at fill_addr[5:2].
module cache_line_mover
  import cache_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  cache_line_mover_if.master bus
);
  state_t            state_q;
  logic              wb_pend_q;
  logic              fill_pend_q;
  logic [TAG_W-1:0]  wb_tag_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [LINE_W-1:0] wb_line_q;
  logic [LINE_W-1:0] fill_line_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              fill_done_q;
  logic              wb_done_q;
  logic              mem_err_q;
  logic              busy_q;

  logic              accept;
  logic              ack;
  logic              expired;
  logic [IDX_W-1:0]  cnt_d;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  rd_idx_d;
  logic [IDX_W-1:0]  acc_start;
  logic [IDX_W-1:0]  fill_start;
  logic              unused_bits;

  assign accept   = (state_q == IDLE) && (bus.wb_req || bus.fill_req);
  assign ack      = mem_req_q && bus.mem_ack;
  assign cnt_d    = cnt_q + 1'b1;
  assign rd_idx   = cnt_q + fill_start;
  assign rd_idx_d = cnt_d + fill_start;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] crit_q;

  assign acc_start  = bus.fill_addr[OFFSET_LSB-1:2];
  assign fill_start = crit_q;

  // Remember the critical word of the accepted fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crit_q <= '0;
    end else if (accept) begin
      crit_q <= acc_start;
    end
  end
`else
  assign acc_start  = '0;
  assign fill_start = '0;
`endif

  assign unused_bits = ^{bus.fill_addr[OFFSET_LSB-1:0],
                         bus.wb_addr[OFFSET_LSB-1:0]};

  beat_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept || ack),
    .en_i      (mem_req_q && !bus.mem_ack),
    .expired_o (expired)
  );

  // Transfer sequencer: IDLE -> WB -> FILL -> DONE, beat registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wb_pend_q   <= 1'b0;
      fill_pend_q <= 1'b0;
      wb_tag_q    <= '0;
      fill_tag_q  <= '0;
      wb_line_q   <= '0;
      fill_line_q <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_done_q <= 1'b0;
      wb_done_q   <= 1'b0;
      mem_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      wb_done_q   <= 1'b0;
      mem_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            wb_pend_q   <= bus.wb_req;
            fill_pend_q <= bus.fill_req;
            wb_tag_q    <= bus.wb_addr[31:OFFSET_LSB];
            fill_tag_q  <= bus.fill_addr[31:OFFSET_LSB];
            wb_line_q   <= bus.wb_line;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            if (bus.wb_req) begin
              state_q     <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {bus.wb_addr[31:OFFSET_LSB], 4'd0, 2'b00};
              mem_wdata_q <= line_word(bus.wb_line, 4'd0);
            end else begin
              state_q     <= FILL;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {bus.fill_addr[31:OFFSET_LSB], acc_start, 2'b00};
              mem_wdata_q <= '0;
            end
          end
        end
        WB: begin
          if (ack) begin
            if (cnt_q == 4'd15) begin
              wb_done_q <= 1'b1;
              wb_pend_q <= 1'b0;
              cnt_q     <= '0;
              if (fill_pend_q) begin
                state_q     <= FILL;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= {fill_tag_q, fill_start, 2'b00};
                mem_wdata_q <= '0;
              end else begin
                state_q   <= DONE;
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
              end
            end else begin
              cnt_q       <= cnt_d;
              mem_addr_q  <= {wb_tag_q, cnt_d, 2'b00};
              mem_wdata_q <= line_word(wb_line_q, cnt_d);
            end
          end else if (expired) begin
            state_q     <= IDLE;
            mem_err_q   <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            wb_pend_q   <= 1'b0;
            fill_pend_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        FILL: begin
          if (ack) begin
            fill_line_q[{rd_idx, 5'b0} +: BEAT_W] <= bus.mem_rdata;
            if (cnt_q == 4'd15) begin
              state_q     <= DONE;
              fill_done_q <= 1'b1;
              fill_pend_q <= 1'b0;
              mem_req_q   <= 1'b0;
              cnt_q       <= '0;
            end else begin
              cnt_q      <= cnt_d;
              mem_addr_q <= {fill_tag_q, rd_idx_d, 2'b00};
            end
          end else if (expired) begin
            state_q     <= IDLE;
            mem_err_q   <= 1'b1;
            mem_req_q   <= 1'b0;
            wb_pend_q   <= 1'b0;
            fill_pend_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fill_line = fill_line_q;
  assign bus.fill_done = fill_done_q;
  assign bus.wb_done   = wb_done_q;
  assign bus.busy      = busy_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
